// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Single-clock instruction memory with a byte-stream program
//            loader and a registered, one-cycle-latency fetch port.
//            Incoming bytes are packed little-endian into DATA_WIDTH-bit
//            words and written to consecutive addresses starting at 0.
// Ports    :
//   clock            - rising-edge clock
//   reset_n          - asynchronous active-low reset
//   load_start       - request a new load (honoured in IDLE/DONE only)
//   load_word_count  - number of words to load, latched with load_start
//   load_byte_valid  - load_byte carries a program byte
//   load_byte        - program byte, little-endian within the word
//   load_byte_ready  - a byte is accepted this cycle (LOAD only)
//   load_busy        - loader is in LOAD
//   load_done        - last load completed; held until the next accepted start
//   load_error       - one-cycle pulse on a rejected load_start
//   fetch_enable     - fetch request
//   fetch_address    - fetch word address
//   fetch_data       - fetched word
//   fetch_valid      - fetch_data updated this cycle
//   fetch_error      - the last fetch was out of range
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader #(
  parameter int DATA_WIDTH = 32,   // multiple of 8
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 1701  // DEPTH <= 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_word_count,
  input  logic                  load_byte_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_byte_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  input  logic                  fetch_enable,
  input  logic [ADDR_WIDTH-1:0] fetch_address,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_valid,
  output logic                  fetch_error
);

  localparam int c_BPW    = DATA_WIDTH / 8;
  localparam int c_BCNT_W = (c_BPW > 1) ? $clog2(c_BPW) : 1;
  localparam int c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0]   c_DEPTH     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [c_BCNT_W-1:0]   c_BCNT_ONE  = c_BCNT_W'(1);
  localparam logic [c_BCNT_W-1:0]   c_LAST_BYTE = c_BCNT_W'(c_BPW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [c_BCNT_W-1:0]   r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_asm;

  // Storage is deliberately left without reset so a program survives reset.
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  w_accept;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_wr_en;
  logic                  w_start_ok;
  logic                  w_fetch_in_range;
  logic                  w_bypass;
  logic [DATA_WIDTH-1:0] w_word;
  logic [c_IDX_W-1:0]    w_wr_idx;
  logic [c_IDX_W-1:0]    w_fetch_idx;

  // load_byte_ready is a registered copy of "state is LOAD", so it doubles
  // as the in-LOAD qualifier for byte acceptance.
  assign w_accept    = load_byte_valid & load_byte_ready;
  assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);
  assign w_last_word = ({1'b0, r_ptr} == (r_count - c_CNT_ONE));
  assign w_wr_en     = w_accept & w_last_byte;
  assign w_start_ok  = (load_word_count != '0) && (load_word_count <= c_DEPTH);

  assign w_wr_idx         = r_ptr[c_IDX_W-1:0];
  assign w_fetch_idx      = fetch_address[c_IDX_W-1:0];
  assign w_fetch_in_range = ({1'b0, fetch_address} < c_DEPTH);
  assign w_bypass         = w_wr_en && (r_ptr == fetch_address);

  // The word written on the final byte is the assembly register with its top
  // lane replaced by the byte arriving on this very edge.
  always_comb begin
    w_word = r_asm;
    w_word[DATA_WIDTH-1 -: 8] = load_byte;
  end

  // --------------------------------------------------------------------------
  // Loader state machine with registered status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_count         <= '0;
      r_ptr           <= '0;
      r_byte_cnt      <= '0;
      r_asm           <= '0;
      load_byte_ready <= 1'b0;
      load_busy       <= 1'b0;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
    end else begin
      load_error <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (load_start) begin
            if (w_start_ok) begin
              r_count         <= load_word_count;
              r_ptr           <= '0;
              r_byte_cnt      <= '0;
              r_asm           <= '0;
              load_done       <= 1'b0;
              load_busy       <= 1'b1;
              load_byte_ready <= 1'b1;
              r_state         <= S_LOAD;
            end else begin
              // Rejected request: flag it, keep state and load_done as is.
              load_error <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          // load_start is ignored while a load is in progress.
          if (w_accept) begin
            if (w_last_byte) begin
              r_byte_cnt <= '0;
              r_ptr      <= r_ptr + c_PTR_ONE;
              if (w_last_word) begin
                load_busy       <= 1'b0;
                load_byte_ready <= 1'b0;
                load_done       <= 1'b1;
                r_state         <= S_DONE;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + c_BCNT_ONE;
              for (int i = 0; i < c_BPW; i++) begin
                if (r_byte_cnt == c_BCNT_W'(i)) begin
                  r_asm[8*i +: 8] <= load_byte;
                end
              end
            end
          end
        end

        default: begin
          r_state         <= S_IDLE;
          load_busy       <= 1'b0;
          load_byte_ready <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Memory write port (no reset on the array)
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      mem[w_wr_idx] <= w_word;
    end
  end

  // --------------------------------------------------------------------------
  // Registered fetch port, write-first on an address collision
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
      fetch_error <= 1'b0;
    end else begin
      fetch_valid <= fetch_enable;
      if (fetch_enable) begin
        if (w_fetch_in_range) begin
          fetch_error <= 1'b0;
          fetch_data  <= w_bypass ? w_word : mem[w_fetch_idx];
        end else begin
          fetch_error <= 1'b1;
          fetch_data  <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loader
// Purpose  : Self-checking bench for instr_mem_loader. A driver issues
//            directed and random stimulus and updates a word-level reference
//            model; a monitor compares DUT outputs against it every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 1701;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_start = 1'b0;
  logic [AW:0]   load_word_count = '0;
  logic          load_byte_valid = 1'b0;
  logic [7:0]    load_byte = '0;
  logic          load_byte_ready;
  logic          load_busy;
  logic          load_done;
  logic          load_error;
  logic          fetch_enable = 1'b0;
  logic [AW-1:0] fetch_address = '0;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          fetch_error;

  instr_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .load_start(load_start), .load_word_count(load_word_count),
    .load_byte_valid(load_byte_valid), .load_byte(load_byte),
    .load_byte_ready(load_byte_ready), .load_busy(load_busy),
    .load_done(load_done), .load_error(load_error),
    .fetch_enable(fetch_enable), .fetch_address(fetch_address),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid),
    .fetch_error(fetch_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  bit          m_loading, m_done;
  int          m_nwords, m_ptr;
  logic [7:0]  m_buf[$];
  bit          exp_busy, exp_done, exp_err, exp_fv, exp_ferr;

  typedef struct {
    bit          chk;
    logic [31:0] data;
    bit          err;
  } fexp_t;
  fexp_t fq[$];

  logic [7:0] stim_q[$];

  task automatic push_word(logic [31:0] w);
    for (int k = 0; k < 4; k++) stim_q.push_back(w[8*k +: 8]);
  endtask

  // One clock cycle: drive at negedge, update model at the following posedge.
  task automatic step(bit st, int cnt, bit bv, logic [7:0] b, bit fe, int fa);
    fexp_t e;
    @(negedge clock);
    load_start = st; load_word_count = (AW+1)'(cnt);
    load_byte_valid = bv; load_byte = b;
    fetch_enable = fe; fetch_address = AW'(fa);
    @(posedge clock);
    exp_err = 1'b0;
    if (!m_loading) begin
      if (st) begin
        if (cnt >= 1 && cnt <= DEPTH) begin
          m_loading = 1'b1; m_done = 1'b0; m_nwords = cnt; m_ptr = 0;
          m_buf.delete();
        end else begin
          exp_err = 1'b1;
        end
      end
    end else if (bv) begin
      m_buf.push_back(b);
      if (m_buf.size() == 4) begin
        ref_mem[m_ptr]   = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
        ref_known[m_ptr] = 1'b1;
        m_buf.delete();
        m_ptr++;
        if (m_ptr == m_nwords) begin
          m_loading = 1'b0; m_done = 1'b1;
        end
      end
    end
    // Fetch is evaluated after the write so a collision sees the new word.
    exp_fv = fe;
    if (fe) begin
      if (fa < DEPTH) begin
        e.chk = ref_known[fa]; e.data = ref_mem[fa]; e.err = 1'b0;
        exp_ferr = 1'b0;
      end else begin
        e.chk = 1'b1; e.data = '0; e.err = 1'b1;
        exp_ferr = 1'b1;
      end
      fq.push_back(e);
    end
    exp_busy = m_loading;
    exp_done = m_done;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic fetch(int fa);
    step(0, 0, 0, 8'h00, 1, fa);
  endtask

  task automatic rand_fetch(bit en, output bit fe, output int fa);
    int r;
    fe = 1'b0; fa = 0;
    if (en) begin
      fe = 1'($urandom_range(1, 0));
      r  = $urandom_range(9, 0);
      if (r < 7)      fa = $urandom_range(15, 0);
      else if (r < 9) fa = $urandom_range(4095, DEPTH);
      else            fa = m_ptr;
    end
  endtask

  // Start a load of cnt words and stream stim_q. last_fetch >= 0 issues a
  // fetch of that address together with the final byte.
  task automatic load_stream(int cnt, bit rnd, int max_gap, int last_fetch);
    bit fe; int fa; int g;
    step(1, cnt, 0, 8'h00, 0, 0);
    for (int i = 0; i < stim_q.size(); i++) begin
      g = rnd ? $urandom_range(max_gap, 0) : max_gap;
      repeat (g) begin
        rand_fetch(rnd, fe, fa);
        step(rnd && ($urandom_range(7, 0) == 0), $urandom_range(2000, 0),
             0, 8'($urandom), fe, fa);
      end
      rand_fetch(rnd, fe, fa);
      if (i == stim_q.size() - 1 && last_fetch >= 0) begin
        fe = 1'b1; fa = last_fetch;
      end
      step(0, 0, 1, stim_q[i], fe, fa);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    load_start = 0; load_byte_valid = 0; fetch_enable = 0;
    #1;
    check("rst_ready", load_byte_ready, 0);
    check("rst_busy", load_busy, 0);
    check("rst_done", load_done, 0);
    check("rst_error", load_error, 0);
    check("rst_fvalid", fetch_valid, 0);
    check("rst_ferror", fetch_error, 0);
    check("rst_fdata", fetch_data, 0);
    m_loading = 0; m_done = 0; m_buf.delete();
    exp_busy = 0; exp_done = 0; exp_err = 0; exp_fv = 0; exp_ferr = 0;
    fq.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    fexp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n) begin
        check("load_busy", load_busy, exp_busy);
        check("load_byte_ready", load_byte_ready, exp_busy);
        check("load_done", load_done, exp_done);
        check("load_error", load_error, exp_err);
        check("fetch_valid", fetch_valid, exp_fv);
        check("fetch_error", fetch_error, exp_ferr);
        if (exp_fv) begin
          if (fq.size() == 0) begin
            check("fetch_queue_nonempty", 0, 1);
          end else begin
            e = fq.pop_front();
            if (fetch_valid) begin
              if (e.chk) check("fetch_data", fetch_data, e.data);
              check("fetch_err_entry", fetch_error, e.err);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;

    // Reset and idle fetch
    do_reset();
    fetch(0);
    idle(1);

    // Basic load
    stim_q.delete();
    push_word(32'h12345678); push_word(32'hDEADBEEF);
    load_stream(2, 0, 0, -1);
    idle(1);
    fetch(0); fetch(1);
    idle(1);

    // Rejected starts in DONE keep load_done
    step(1, 0, 0, 8'h00, 0, 0);
    idle(1);
    step(1, 1702, 0, 8'h00, 0, 0);
    idle(1);

    // Overwrite then stalled reload of the same stream
    stim_q.delete();
    push_word(32'h0BADF00D); push_word(32'h55AA55AA);
    load_stream(2, 0, 0, -1);
    stim_q.delete();
    push_word(32'h12345678); push_word(32'hDEADBEEF);
    load_stream(2, 0, 3, -1);
    fetch(0); fetch(1);

    // Out-of-range fetches, then in-range clears the error
    fetch(1701); fetch(4095); idle(1); fetch(1); idle(1);

    // Bypass on word 5
    stim_q.delete();
    for (int i = 0; i < 5; i++) push_word($urandom);
    push_word(32'hCAFEF00D);
    load_stream(6, 0, 0, 5);
    fetch(5); fetch(4);

    // Reset mid-load
    stim_q.delete();
    for (int i = 0; i < 3; i++) push_word($urandom);
    load_stream(3, 0, 0, -1);
    stim_q.delete();
    for (int i = 0; i < 3; i++) push_word($urandom);
    step(1, 3, 0, 8'h00, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, stim_q[i], 0, 0);
    do_reset();
    idle(1);
    fetch(0); fetch(1); fetch(2);
    step(1, 0, 0, 8'h00, 0, 0);      // rejected in IDLE
    idle(1);
    stim_q.delete();
    push_word(32'hA5A5_0001); push_word(32'hA5A5_0002);
    load_stream(2, 0, 1, -1);
    fetch(0); fetch(1); fetch(2);

    // Randomized loads with concurrent fetches and spurious starts
    for (int t = 0; t < 25; t++) begin
      cnt = $urandom_range(10, 1);
      stim_q.delete();
      for (int i = 0; i < cnt; i++) push_word($urandom);
      if ($urandom_range(3, 0) == 0) begin
        step(1, ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(4000, DEPTH + 1),
             0, 8'h00, 0, 0);
      end
      load_stream(cnt, 1, 2, ($urandom_range(1, 0) == 0) ? cnt - 1 : -1);
      for (int a = 0; a < 16; a++) fetch(a);
    end

    idle(2);
    check("scoreboard_drained", fq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
